cv_smoother: RTL and testbench



---
 rtl/cv_smoother_pkg.sv | 36 +++
 rtl/cv_iir_channel.sv | 46 ++++
 rtl/cv_smoother.sv | 165 ++++++++++++++++
 tb/tb_cv_smoother.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cv_smoother_pkg.sv
// ============================================================================
// Module      : cv_smoother_pkg
// Description : Shared constants, FSM state type and frequency clamp helper
//               for the CV smoother.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv_smoother_pkg;

    localparam int unsigned c_samplerate      = 48000;
    // fpga_clock cycles per audio sample at 72 MHz
    localparam int unsigned c_sample_interval = 1500;

    localparam logic [15:0] c_freq_min_default = 16'd1;
    localparam logic [15:0] c_freq_max_default = 16'd24000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_FILT0   = 3'd2,
        ST_FILT1   = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    function automatic logic [15:0] clamp_u16(input logic [15:0] v,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cv_iir_channel.sv
// ============================================================================
// Module      : cv_iir_channel
// Description : One-pole IIR low-pass (coefficient 2^-FILTER_SHIFT) with a
//               preload path that seeds the accumulator from the input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv_iir_channel #(
    parameter int unsigned FILTER_SHIFT = 3,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              i_clock,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_preload,
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_y
);

    localparam int unsigned c_acc_w = DATA_W + FILTER_SHIFT;

    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_x_ext;
    logic [c_acc_w-1:0] w_step;
    logic [c_acc_w-1:0] w_load;

    assign w_x_ext = {{FILTER_SHIFT{1'b0}}, i_x};
    assign w_load  = {i_x, {FILTER_SHIFT{1'b0}}};
    // acc never exceeds max(x)<<SHIFT, so the true result always fits and the
    // modular intermediate (acc + x may wrap) resolves to the exact value.
    assign w_step  = r_acc + w_x_ext - (r_acc >> FILTER_SHIFT);

    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_preload ? w_load : w_step;
        end
    end

    assign o_y = r_acc[c_acc_w-1:FILTER_SHIFT];

endmodule

`default_nettype wire

// File: rtl/cv_smoother.sv
// ============================================================================
// Module      : cv_smoother
// Description : Synchronises the ADC frame strobe, IIR-filters both CV
//               channels, clamps frequency and presents registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv_smoother
    import cv_smoother_pkg::*;
#(
    parameter int unsigned FILTER_SHIFT = 3,
    parameter logic [15:0] FREQ_MIN     = c_freq_min_default,
    parameter logic [15:0] FREQ_MAX     = c_freq_max_default,
    parameter logic [15:0] FREQ_RESET   = 16'd1000,
    parameter logic [15:0] SCALE_RESET  = 16'd0
) (
    input  logic        i_clock,
    input  logic        i_rstn,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
    input  logic        i_data_received,
    output logic [15:0] o_frequency,
    output logic [15:0] o_harmonic_scale,
    output logic        o_valid,
    output logic        o_overrun
);

    logic [1:0]  r_sync;
    logic        r_sync_prev;
    logic        r_pending;
    logic        r_primed;
    logic [15:0] r_x0;
    logic [15:0] r_x1;
    logic [15:0] r_frequency;
    logic [15:0] r_scale;
    logic        r_valid;
    logic        r_overrun;
    state_t      r_state;
    state_t      w_state_next;

    logic        w_edge;
    logic        w_pending_clear;
    logic        w_capture;
    logic        w_filt0;
    logic        w_filt1;
    logic        w_output;
    logic [15:0] w_y0;
    logic [15:0] w_y1;

    assign w_edge = r_sync[1] & ~r_sync_prev;

    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync      <= 2'b00;
            r_sync_prev <= 1'b0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_data_received};
            r_sync_prev <= r_sync[1];
            // A new edge wins over the IDLE clear, so a frame is never lost.
            r_pending   <= w_edge | (r_pending & ~w_pending_clear);
            r_overrun   <= w_edge & r_pending & ~w_pending_clear;
        end
    end

    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pending_clear = 1'b0;
        w_capture       = 1'b0;
        w_filt0         = 1'b0;
        w_filt1         = 1'b0;
        w_output        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_pending_clear = 1'b1;
                    w_state_next    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = ST_FILT0;
            end
            ST_FILT0: begin
                w_filt0      = 1'b1;
                w_state_next = ST_FILT1;
            end
            ST_FILT1: begin
                w_filt1      = 1'b1;
                w_state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                w_output     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_x0        <= 16'd0;
            r_x1        <= 16'd0;
            r_primed    <= 1'b0;
            r_frequency <= FREQ_RESET;
            r_scale     <= SCALE_RESET;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_output;
            if (w_capture) begin
                r_x0 <= i_data0;
                r_x1 <= i_data1;
            end
            if (w_filt1) begin
                r_primed <= 1'b1;
            end
            if (w_output) begin
                r_frequency <= clamp_u16(w_y0, FREQ_MIN, FREQ_MAX);
                r_scale     <= w_y1;
            end
        end
    end

    cv_iir_channel #(
        .FILTER_SHIFT (FILTER_SHIFT),
        .DATA_W       (16)
    ) u_iir_freq (
        .i_clock   (i_clock),
        .i_rstn    (i_rstn),
        .i_en      (w_filt0),
        .i_preload (~r_primed),
        .i_x       (r_x0),
        .o_y       (w_y0)
    );

    cv_iir_channel #(
        .FILTER_SHIFT (FILTER_SHIFT),
        .DATA_W       (16)
    ) u_iir_scale (
        .i_clock   (i_clock),
        .i_rstn    (i_rstn),
        .i_en      (w_filt1),
        .i_preload (~r_primed),
        .i_x       (r_x1),
        .o_y       (w_y1)
    );

    assign o_frequency      = r_frequency;
    assign o_harmonic_scale = r_scale;
    assign o_valid          = r_valid;
    assign o_overrun        = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_cv_smoother.sv
// ============================================================================
// Module      : tb_cv_smoother
// Description : Directed self-checking bench for cv_smoother.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cv_smoother;

    logic        r_clock = 1'b0;
    logic        r_rstn;
    logic [15:0] r_data0;
    logic [15:0] r_data1;
    logic        r_data_received;
    logic [15:0] w_frequency;
    logic [15:0] w_harmonic_scale;
    logic        w_valid;
    logic        w_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 r_clock = ~r_clock;

    cv_smoother u_dut (
        .i_clock          (r_clock),
        .i_rstn           (r_rstn),
        .i_data0          (r_data0),
        .i_data1          (r_data1),
        .i_data_received  (r_data_received),
        .o_frequency      (w_frequency),
        .o_harmonic_scale (w_harmonic_scale),
        .o_valid          (w_valid),
        .o_overrun        (w_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge r_clock);
        r_rstn          = 1'b0;
        r_data_received = 1'b0;
        repeat (3) @(negedge r_clock);
        r_rstn = 1'b1;
        repeat (2) @(negedge r_clock);
    endtask

    // Pulses the strobe for 3 cycles and returns cycles until o_valid (0 = none).
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge r_clock);
        r_data0         = a;
        r_data1         = b;
        r_data_received = 1'b1;
        lat             = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge r_clock);
            if (i == 3) r_data_received = 1'b0;
            if (w_valid) begin
                lat = i;
                break;
            end
        end
        r_data_received = 1'b0;
        if (lat == 0) check("valid_timeout", 0, 1);
        @(negedge r_clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt_valid;
        int cnt_ovr;
        logic [15:0] prev_scale;
        logic        no_wrap;

        r_rstn          = 1'b0;
        r_data0         = 16'd0;
        r_data1         = 16'd0;
        r_data_received = 1'b0;
        repeat (4) @(negedge r_clock);
        check("rst_freq",    w_frequency, 1000);
        check("rst_scale",   w_harmonic_scale, 0);
        check("rst_valid",   w_valid, 0);
        check("rst_overrun", w_overrun, 0);

        r_rstn    = 1'b1;
        cnt_valid = 0;
        repeat (6) begin
            @(negedge r_clock);
            if (w_valid) cnt_valid++;
        end
        check("idle_no_valid", cnt_valid, 0);
        check("idle_freq",     w_frequency, 1000);

        // First frame preloads the filter
        send_frame(16'd1000, 16'h4000, lat);
        check("first_latency_7_9", (lat >= 7 && lat <= 9), 1);
        check("first_freq",  w_frequency, 1000);
        check("first_scale", w_harmonic_scale, 16'h4000);
        check("valid_one_cycle", w_valid, 0);

        // Step response 1000 -> 2000
        send_frame(16'd2000, 16'h4000, lat);
        check("step1_freq", w_frequency, 1125);
        check("step1_scale", w_harmonic_scale, 16'h4000);
        send_frame(16'd2000, 16'h4000, lat);
        check("step2_freq", w_frequency, 1234);
        send_frame(16'd2000, 16'h4000, lat);
        check("step3_freq", w_frequency, 1330);
        repeat (57) send_frame(16'd2000, 16'h4000, lat);
        check("step_converged", (w_frequency >= 1999 && w_frequency <= 2001), 1);

        // Clamps and full-scale convergence
        apply_reset();
        send_frame(16'd0, 16'd0, lat);
        check("clamp_min_freq", w_frequency, 1);
        check("clamp_min_scale", w_harmonic_scale, 0);
        prev_scale = w_harmonic_scale;
        no_wrap    = 1'b1;
        repeat (100) begin
            send_frame(16'hFFFF, 16'hFFFF, lat);
            if (w_harmonic_scale < prev_scale) no_wrap = 1'b0;
            prev_scale = w_harmonic_scale;
        end
        check("clamp_max_freq", w_frequency, 24000);
        check("scale_full",     w_harmonic_scale, 16'hFFFF);
        check("scale_no_wrap",  no_wrap, 1);

        // Asynchronous reset while the FSM sits in FILT1
        @(negedge r_clock);
        r_data0         = 16'd7777;
        r_data1         = 16'd1234;
        r_data_received = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge r_clock);
            if (i == 3) r_data_received = 1'b0;
        end
        r_rstn = 1'b0;
        #1;
        check("midrst_freq",  w_frequency, 1000);
        check("midrst_scale", w_harmonic_scale, 0);
        check("midrst_valid", w_valid, 0);
        repeat (2) @(negedge r_clock);
        r_rstn    = 1'b1;
        cnt_valid = 0;
        repeat (10) begin
            @(negedge r_clock);
            if (w_valid) cnt_valid++;
        end
        check("midrst_no_valid", cnt_valid, 0);
        send_frame(16'd500, 16'd77, lat);
        check("post_rst_freq",  w_frequency, 500);
        check("post_rst_scale", w_harmonic_scale, 77);

        // Overrun: three strobes two cycles apart
        apply_reset();
        @(negedge r_clock);
        r_data0 = 16'd100; r_data1 = 16'd10; r_data_received = 1'b1;
        @(negedge r_clock);
        r_data_received = 1'b0;
        @(negedge r_clock);
        r_data0 = 16'd200; r_data1 = 16'd20; r_data_received = 1'b1;
        @(negedge r_clock);
        r_data_received = 1'b0;
        @(negedge r_clock);
        r_data0 = 16'd300; r_data1 = 16'd30; r_data_received = 1'b1;
        @(negedge r_clock);
        r_data_received = 1'b0;
        cnt_valid = 0;
        cnt_ovr   = 0;
        repeat (30) begin
            @(negedge r_clock);
            if (w_valid)   cnt_valid++;
            if (w_overrun) cnt_ovr++;
        end
        check("ovr_pulses",   cnt_ovr, 1);
        check("ovr_valids",   cnt_valid, 2);
        check("ovr_freq",     w_frequency, 300);
        check("ovr_scale",    w_harmonic_scale, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
